// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants, FSM state encoding and word-length helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int OVERSAMPLE    = 16;
    localparam int NBITS_MIN     = 5;
    localparam int NBITS_MAX     = 8;
    localparam int BAUD_9600_50M = 325;

    // Out-of-range word lengths fall back to a full byte.
    function automatic logic [3:0] effNBits(input logic [3:0] nb);
        return (nb >= 4'(NBITS_MIN) && nb <= 4'(NBITS_MAX)) ? nb : 4'(NBITS_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Show-ahead synchronous FIFO feeding the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr  = wr_en && !full;
    assign w_rd  = rd_en && !empty;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rdPtr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_rd) r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wrPtr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : FIFO-buffered 16x-oversampled UART transmitter (start, 5..8 data, stop).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Tick,
    input  logic                          TxEn,
    input  logic [3:0]                    NBits,
    input  logic [7:0]                    InData,
    input  logic                          InValid,
    output logic                          InReady,
    output logic                          Tx,
    output logic                          TxDone,
    output logic                          Busy,
    output logic [$clog2(FIFO_DEPTH):0]   Count
);

    logic [1:0] r_state;
    logic [3:0] r_tc;
    logic [2:0] r_bi;
    logic [3:0] r_nb;
    logic [7:0] r_shift;
    logic       r_tx;
    logic       r_txDone;
    logic       r_busy;

    logic [7:0] w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;
    logic       w_tcLast;
    logic       w_lastBit;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .wr_en (InValid),
        .rd_en (w_pop),
        .din   (InData),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (Count)
    );

    assign InReady   = !w_full;
    assign w_pop     = (r_state == IDLE) && TxEn && !w_empty;
    assign w_tcLast  = (r_tc == 4'(OVERSAMPLE - 1));
    assign w_lastBit = ({1'b0, r_bi} == (r_nb - 4'd1));

    assign Tx     = r_tx;
    assign TxDone = r_txDone;
    assign Busy   = r_busy;

    // Tx is loaded with the level of the state being entered, so it changes on the transition edge.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state  <= IDLE;
            r_tc     <= '0;
            r_bi     <= '0;
            r_nb     <= 4'd8;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_txDone <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_txDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_nb    <= effNBits(NBits);
                        r_tc    <= '0;
                        r_bi    <= '0;
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (Tick) begin
                        r_tc <= r_tc + 4'd1;
                        if (w_tcLast) begin
                            r_state <= DATA;
                            r_tx    <= r_shift[0];
                        end
                    end
                end
                DATA: begin
                    if (Tick) begin
                        r_tc <= r_tc + 4'd1;
                        if (w_tcLast) begin
                            r_shift <= {1'b1, r_shift[7:1]};
                            if (w_lastBit) begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end else begin
                                r_bi <= r_bi + 3'd1;
                                r_tx <= r_shift[1];
                            end
                        end
                    end
                end
                STOP: begin
                    if (Tick) begin
                        r_tc <= r_tc + 4'd1;
                        if (w_tcLast) begin
                            r_state  <= IDLE;
                            r_txDone <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Scoreboard bench: writes push expected frames, a Tx-line monitor decodes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int OVER = 16;

    typedef struct packed {
        logic [3:0] nb;
        logic [7:0] d;
    } exp_t;

    logic       Clk;
    logic       Rst_n;
    logic       Tick;
    logic       TxEn;
    logic [3:0] NBits;
    logic [7:0] InData;
    logic       InValid;
    logic       InReady;
    logic       Tx;
    logic       TxDone;
    logic       Busy;
    logic [3:0] Count;

    exp_t sbQ[$];
    int   total = 0;
    int   bad = 0;
    int   tickPer = 1;
    int   cyc = 0;
    int   lastDone = -1;
    int   doneCount = 0;
    bit   chkGap = 0;
    bit   monEn = 1;
    bit   monBusy = 0;

    uart_tx_buffered #(.FIFO_DEPTH(8)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Tick    (Tick),
        .TxEn    (TxEn),
        .NBits   (NBits),
        .InData  (InData),
        .InValid (InValid),
        .InReady (InReady),
        .Tx      (Tx),
        .TxDone  (TxDone),
        .Busy    (Busy),
        .Count   (Count)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    initial begin
        int tcnt;
        tcnt = 0;
        Tick = 1'b0;
        forever begin
            @(negedge Clk);
            tcnt++;
            if (tcnt >= tickPer) begin
                tcnt = 0;
                Tick = 1'b1;
            end else begin
                Tick = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge Clk);
        if (TxDone) doneCount++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkRange(input string nm, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
        end
    endtask

    // Offer one byte for one cycle; expected frame goes to the scoreboard when accepted.
    task automatic wr(input logic [7:0] d, input logic [3:0] nbAtPop, input bit expAccept, input bit track);
        InData  = d;
        InValid = 1'b1;
        chk("inready at write", InReady, expAccept);
        if (expAccept && track)
            sbQ.push_back('{nb: (nbAtPop >= 4'd5 && nbAtPop <= 4'd8) ? nbAtPop : 4'd8, d: d});
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || monBusy || Busy) && n < lim) begin
            @(negedge Clk);
            n++;
        end
        chk("drain within budget", n < lim, 1);
    endtask

    // Monitor: decodes each frame on Tx at mid-bit and pops the scoreboard.
    initial begin : monitor
        bit         prevTx;
        exp_t       e;
        int         bitClk;
        int         el;
        int         lim;
        int         expLen;
        logic [7:0] got;
        logic [8:0] m;
        prevTx = 1'b1;
        forever begin
            @(negedge Clk);
            if (monEn && prevTx && !Tx) begin
                monBusy = 1'b1;
                if (chkGap && lastDone >= 0) chk("idle gap between frames", cyc - lastDone, 1);
                chk("frame expected by scoreboard", sbQ.size() != 0, 1);
                if (sbQ.size() != 0) e = sbQ.pop_front();
                else e = '{nb: 4'd8, d: 8'h00};
                bitClk = OVER * tickPer;
                el = 0;
                repeat (bitClk / 2) begin @(negedge Clk); el++; end
                chk("start bit level", Tx, 0);
                got = '0;
                for (int i = 0; i < int'(e.nb); i++) begin
                    repeat (bitClk) begin @(negedge Clk); el++; end
                    got[i] = Tx;
                end
                repeat (bitClk) begin @(negedge Clk); el++; end
                chk("stop bit level", Tx, 1);
                lim = el + bitClk;
                while (!TxDone && el < lim) begin @(negedge Clk); el++; end
                m = (9'd1 << e.nb) - 9'd1;
                chk("decoded data", got, e.d & m[7:0]);
                expLen = OVER * (int'(e.nb) + 2) * tickPer;
                chkRange("frame length to TxDone", el, expLen - tickPer + 1, expLen);
                lastDone = cyc;
                monBusy = 1'b0;
            end
            prevTx = Tx;
        end
    end

    initial begin : stim
        int lowCnt;
        Rst_n   = 1'b0;
        TxEn    = 1'b0;
        NBits   = 4'd8;
        InData  = 8'h00;
        InValid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset Tx", Tx, 1);
        chk("reset TxDone", TxDone, 0);
        chk("reset Busy", Busy, 0);
        chk("reset Count", Count, 0);
        chk("reset InReady", InReady, 1);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Single byte, Tick tied high, start latency
        TxEn = 1'b1;
        wr(8'h55, 4'd8, 1, 1);
        chk("latency Count after write", Count, 1);
        chk("latency Tx still idle", Tx, 1);
        @(negedge Clk);
        chk("latency Tx low after pop", Tx, 0);
        chk("latency Busy after pop", Busy, 1);
        chk("latency Count after pop", Count, 0);
        drain(1000);

        // Burst with backpressure
        TxEn = 1'b0;
        for (int i = 1; i <= 9; i++) wr(8'(i), 4'd8, i <= 8, 1);
        chk("full InReady", InReady, 0);
        chk("full Count", Count, 8);
        lastDone = -1;
        chkGap = 1'b1;
        TxEn = 1'b1;
        drain(3000);
        chkGap = 1'b0;

        // Short word then out-of-range word length
        NBits = 4'd5;
        wr(8'hFF, 4'd5, 1, 1);
        @(negedge Clk);
        NBits = 4'd2;
        wr(8'h80, 4'd2, 1, 1);
        drain(1000);

        // Write on the pop cycle, then drop TxEn mid-frame
        NBits = 4'd8;
        wr(8'h3C, 4'd8, 1, 1);
        wr(8'hC3, 4'd8, 1, 1);
        chk("write on pop Count", Count, 1);
        chk("write on pop Busy", Busy, 1);
        repeat (40) @(negedge Clk);
        TxEn = 1'b0;
        repeat (200) @(negedge Clk);
        chk("TxEn low no new frame Busy", Busy, 0);
        chk("TxEn low byte retained", Count, 1);
        chk("TxEn low Tx idle", Tx, 1);
        TxEn = 1'b1;
        drain(1000);

        // Reset during data bit 3
        monEn = 1'b0;
        TxEn = 1'b0;
        for (int i = 0; i < 3; i++) wr(8'hF0 + 8'(i), 4'd8, 1, 0);
        TxEn = 1'b1;
        repeat (1 + 64 + 8) @(negedge Clk);
        chk("mid-frame Busy before reset", Busy, 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk("mid-reset Tx", Tx, 1);
        chk("mid-reset Count", Count, 0);
        chk("mid-reset Busy", Busy, 0);
        chk("mid-reset InReady", InReady, 1);
        Rst_n = 1'b1;
        lowCnt = 0;
        repeat (300) begin
            @(negedge Clk);
            if (!Tx) lowCnt++;
        end
        chk("no frames after reset", lowCnt, 0);
        chk("idle after reset Busy", Busy, 0);
        monEn = 1'b1;

        // Sparse tick at the 9600-baud rate
        tickPer = 325;
        repeat (2) @(negedge Clk);
        wr(8'hA3, 4'd8, 1, 1);
        drain(60000);

        chk("TxDone pulse count", doneCount, 14);
        chk("scoreboard empty", sbQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
